// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture path.
package la_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 32768;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        WAIT_TRIG = 3'd2,
        CAPTURE   = 3'd3,
        READOUT   = 3'd4
    } cap_state_t;

endpackage

// File: rtl/sample_rate_div.sv
// Sample-rate divider: one tick every rate_div+1 clocks, restartable.
module sample_rate_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    // >= keeps a live decrease of rate_div from stalling a full wrap
    assign tick = (div_cnt >= rate_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Capture controller: arm, trigger, post-trigger capture into the sample
// FIFO, then drain the FIFO to the host over a valid/ready stream.
module capture_sequencer #(
    parameter int DATA_W = la_pkg::DATA_W,
    parameter int CNT_W  = 16,
    parameter int DIV_W  = 16,
    parameter int DEPTH  = la_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [CNT_W-1:0]  post_count,
    input  logic [DATA_W-1:0] probe,
    output logic              fifo_en,
    output logic              fifo_rnw,
    output logic              fifo_clear,
    output logic [DATA_W-1:0] fifo_din,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [CNT_W:0]    sample_count
);

    import la_pkg::*;

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    cap_state_t        state;
    logic [DATA_W-1:0] probe_q;
    logic [CNT_W-1:0]  post_q;
    logic [CNT_W:0]    limit;
    logic              rd_pend;
    logic              tick;
    logic              div_restart;
    logic              trig_hit;
    logic              limit_hit;
    logic              wr;
    logic              rd;
    logic              finish;

    assign div_restart = (state == IDLE) || (state == CLEAR);

    sample_rate_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .restart  (div_restart),
        .rate_div (rate_div),
        .tick     (tick)
    );

    always_comb begin
        limit = {1'b0, post_q};
        if (post_q == '0 || limit > DEPTH_C) begin
            limit = DEPTH_C;
        end
    end

    assign fifo_din  = probe_q;
    assign trig_hit  = ((probe_q ^ trig_value) & trig_mask) == '0;
    assign limit_hit = (sample_count >= limit) || fifo_full;

    assign wr = !abort && !fifo_full && tick &&
                (((state == WAIT_TRIG) && trig_hit) ||
                 ((state == CAPTURE) && !limit_hit));

    // A read may only start when the output register is free this clk
    assign rd = !abort && (state == READOUT) && !fifo_empty &&
                !rd_pend && (!out_valid || out_ready);

    assign finish = !abort && (state == READOUT) && fifo_empty &&
                    !rd_pend && !out_valid;

    assign fifo_en  = wr | rd;
    assign fifo_rnw = !wr;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            probe_q      <= '0;
            post_q       <= '0;
            rd_pend      <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            fifo_clear   <= 1'b0;
            sample_count <= '0;
        end else begin
            probe_q    <= probe;
            done       <= 1'b0;
            fifo_clear <= 1'b0;
            rd_pend    <= rd;

            if (rd_pend) begin
                out_data  <= fifo_dout;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (wr) begin
                if (state == WAIT_TRIG) begin
                    sample_count <= (CNT_W+1)'(1);
                end else begin
                    sample_count <= sample_count + 1'b1;
                end
            end

            if (state != IDLE && abort) begin
                fifo_clear <= 1'b1;
                out_valid  <= 1'b0;
                rd_pend    <= 1'b0;
                state      <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (arm && !abort) begin
                            fifo_clear <= 1'b1;
                            state      <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        sample_count <= '0;
                        triggered    <= 1'b0;
                        post_q       <= post_count;
                        state        <= WAIT_TRIG;
                    end
                    WAIT_TRIG: begin
                        if (wr) begin
                            triggered <= 1'b1;
                            state     <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (limit_hit) begin
                            state <= READOUT;
                        end
                    end
                    READOUT: begin
                        if (finish) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: FIFO model, stream sink, reference predictor.
module tb_capture_sequencer;

    localparam int D   = 4096;
    localparam int NPR = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] rate_div = '0;
    logic [7:0]  trig_mask = '0;
    logic [7:0]  trig_value = '0;
    logic [15:0] post_count = '0;
    logic [7:0]  probe = '0;
    logic        fifo_en, fifo_rnw, fifo_clear;
    logic [7:0]  fifo_din;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy, triggered, done;
    logic [16:0] sample_count;

    capture_sequencer #(.DEPTH(D)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .rate_div(rate_div), .trig_mask(trig_mask),
        .trig_value(trig_value), .post_count(post_count),
        .probe(probe), .fifo_en(fifo_en), .fifo_rnw(fifo_rnw),
        .fifo_clear(fifo_clear), .fifo_din(fifo_din),
        .fifo_dout(fifo_dout), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .triggered(triggered), .done(done),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    // FIFO model
    logic [7:0] mem [D];
    int wp, rp, cnt;
    assign fifo_full  = (cnt == D);
    assign fifo_empty = (cnt == 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= 0; rp <= 0; cnt <= 0; fifo_dout <= '0;
        end else if (fifo_clear) begin
            wp <= 0; rp <= 0; cnt <= 0;
        end else if (fifo_en && !fifo_rnw && cnt < D) begin
            mem[wp] <= fifo_din;
            wp <= (wp + 1) % D;
            cnt <= cnt + 1;
        end else if (fifo_en && fifo_rnw && cnt > 0) begin
            fifo_dout <= mem[rp];
            rp <= (rp + 1) % D;
            cnt <= cnt - 1;
        end
    end

    logic [7:0] pr [NPR];
    logic [7:0] wr_log[$];
    logic [7:0] rx[$];
    logic [7:0] expq[$];
    int wr_cyc[$];
    int pi, cyc, n_chk, n_fail, viol, done_cnt, rd_cnt;
    bit rdy_rand, rdy_fix, mon_on;
    logic pv, p_rdy, pab;
    logic [7:0] pd;

    // Protocol monitor and stream sink, sampled mid-cycle
    always @(negedge clk) begin
        if (!mon_on || reset) begin
            pv = 1'b0;
        end else begin
            if (fifo_en && fifo_clear) viol++;
            if (fifo_en && !fifo_rnw && fifo_full) viol++;
            if (fifo_en && fifo_rnw && fifo_empty) viol++;
            if (fifo_en && fifo_rnw && out_valid && !out_ready) viol++;
            if (pv && !p_rdy && !pab && (!out_valid || out_data !== pd))
                viol++;
            if (fifo_en && !fifo_rnw) begin
                wr_log.push_back(fifo_din);
                wr_cyc.push_back(cyc);
            end
            if (fifo_en && fifo_rnw) rd_cnt++;
            if (out_valid && out_ready) rx.push_back(out_data);
            if (done) done_cnt++;
            pv = out_valid; p_rdy = out_ready; pd = out_data; pab = abort;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        probe = pr[pi];
        if (pi < NPR - 1) pi++;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    endtask

    // Reference: probe_q in WAIT_TRIG cycle j equals pr[j]; ticks fall on
    // j = r, 2r+1, ...; capture the first match then every later tick.
    task automatic predict(input int r, input int post, output int jt);
        int l;
        jt = r;
        while (jt < NPR && ((pr[jt] ^ trig_value) & trig_mask) != 0)
            jt += r + 1;
        l = (post == 0 || post > D) ? D : post;
        expq.delete();
        for (int k = 0; k < l; k++)
            if (jt + k * (r + 1) < NPR) expq.push_back(pr[jt + k * (r + 1)]);
    endtask

    task automatic start_cap(input logic [7:0] m, input logic [7:0] v,
                             input int r, input int post,
                             output int jt, output int ca, output int d0);
        trig_mask = m; trig_value = v;
        rate_div = 16'(r); post_count = 16'(post);
        predict(r, post, jt);
        wr_log.delete(); wr_cyc.delete(); rx.delete();
        d0 = done_cnt;
        step();
        arm = 1'b1;
        pi = 0;
        step();
        arm = 1'b0;
        ca = cyc;
    endtask

    task automatic finish_cap(input string tag, input int r, input int jt,
                              input int ca, input int d0);
        bit to;
        int bad_d, bad_t, bad_r;
        to = 1'b1;
        for (int i = 0; i < 40000; i++) begin
            step();
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        chk({tag, " timeout"}, 32'(to), 32'd0);
        step();
        bad_d = 0; bad_t = 0; bad_r = 0;
        foreach (expq[k]) begin
            if (k >= wr_log.size() || wr_log[k] !== expq[k]) bad_d++;
            if (k >= rx.size() || rx[k] !== expq[k]) bad_r++;
        end
        foreach (wr_cyc[k])
            if (wr_cyc[k] != ca + 1 + jt + k * (r + 1)) bad_t++;
        chk({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, " sample_count"}, 32'(sample_count), 32'(expq.size()));
        chk({tag, " triggered"}, 32'(triggered), 32'd1);
        chk({tag, " wr_len"}, 32'(wr_log.size()), 32'(expq.size()));
        chk({tag, " wr_data_bad"}, 32'(bad_d), 32'd0);
        chk({tag, " wr_timing_bad"}, 32'(bad_t), 32'd0);
        chk({tag, " rx_len"}, 32'(rx.size()), 32'(expq.size()));
        chk({tag, " rx_data_bad"}, 32'(bad_r), 32'd0);
    endtask

    task automatic run_cap(input string tag, input logic [7:0] m,
                           input logic [7:0] v, input int r, input int post);
        int jt, ca, d0;
        start_cap(m, v, r, post, jt, ca, d0);
        finish_cap(tag, r, jt, ca, d0);
    endtask

    task automatic wait_for(input string tag, input int what, input int n);
        bit to;
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            if ((what == 0 && int'(sample_count) >= n) ||
                (what == 1 && out_valid) ||
                (what == 2 && rx.size() >= n)) begin
                to = 1'b0;
                break;
            end
        end
        chk({tag, " wait_timeout"}, 32'(to), 32'd0);
    endtask

    task automatic do_abort(input string tag);
        int d0;
        d0 = done_cnt;
        abort = 1'b1;
        step();
        chk({tag, " clear_pulse"}, 32'(fifo_clear), 32'd1);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " triggered_held"}, 32'(triggered), 32'd1);
        abort = 1'b0;
        step();
        chk({tag, " clear_1clk"}, 32'(fifo_clear), 32'd0);
        step();
        chk({tag, " no_done"}, 32'(done_cnt - d0), 32'd0);
    endtask

    typedef struct {
        logic [7:0] m;
        logic [7:0] v;
        int         r;
        int         post;
        int         exp_n;
        logic [7:0] exp_first;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int jt, ca, d0, sc, snap_rx, snap_rd;
        tbl[0] = '{8'hFF, 8'hA5, 0, 4,    4,    8'hA5};
        tbl[1] = '{8'h00, 8'h00, 3, 3,    3,    8'h03};
        tbl[2] = '{8'hF0, 8'h30, 1, 5,    5,    8'h31};
        tbl[3] = '{8'h0F, 8'h07, 2, 1,    1,    8'h17};
        tbl[4] = '{8'h80, 8'h80, 0, 2,    2,    8'h80};
        tbl[5] = '{8'h00, 8'h00, 0, 0,    D,    8'h00};
        tbl[6] = '{8'h00, 8'h00, 0, 5000, D,    8'h00};
        for (int i = 0; i < NPR; i++) pr[i] = 8'(i);
        rdy_fix = 1'b1;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({fifo_en, fifo_rnw, fifo_clear, out_valid,
                              busy, triggered, done}), 32'b0100000);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_sample_count", 32'(sample_count), 32'd0);
        reset = 1'b0;
        mon_on = 1'b1;
        step();

        foreach (tbl[i]) begin
            for (int k = 0; k < NPR; k++) pr[k] = 8'(k);
            run_cap($sformatf("vec%0d", i), tbl[i].m, tbl[i].v,
                    tbl[i].r, tbl[i].post);
            chk($sformatf("vec%0d n", i), 32'(sample_count),
                32'(tbl[i].exp_n));
            chk($sformatf("vec%0d first", i),
                wr_log.size() > 0 ? 32'(wr_log[0]) : 32'hFFFF_FFFF,
                32'(tbl[i].exp_first));
        end

        for (int n = 0; n < 8; n++) begin
            int r, post, idx;
            for (int k = 0; k < NPR; k++) pr[k] = 8'($urandom);
            r = $urandom_range(0, 4);
            post = $urandom_range(1, 20);
            idx = (r + 1) * $urandom_range(0, 40) + r;
            rdy_rand = 1'b1;
            run_cap($sformatf("rnd%0d", n), 8'($urandom), pr[idx], r, post);
            rdy_rand = 1'b0;
        end

        for (int k = 0; k < NPR; k++) pr[k] = 8'(k);
        start_cap(8'hFF, 8'h10, 0, 6, jt, ca, d0);
        wait_for("stall", 2, 2);
        rdy_fix = 1'b0;
        step();
        snap_rx = rx.size();
        snap_rd = rd_cnt;
        repeat (9) step();
        chk("stall rx_frozen", 32'(rx.size()), 32'(snap_rx));
        chk("stall reads_le1", 32'(rd_cnt - snap_rd <= 1), 32'd1);
        chk("stall valid_held", 32'(out_valid), 32'd1);
        rdy_fix = 1'b1;
        finish_cap("stall", 0, jt, ca, d0);

        start_cap(8'h00, 8'h00, 2, 50, jt, ca, d0);
        wait_for("abort_cap", 0, 3);
        do_abort("abort_cap");

        rdy_fix = 1'b0;
        start_cap(8'h00, 8'h00, 0, 8, jt, ca, d0);
        wait_for("abort_rd", 1, 0);
        do_abort("abort_rd");
        rdy_fix = 1'b1;

        start_cap(8'h00, 8'h00, 1, 20, jt, ca, d0);
        wait_for("arm_busy", 0, 4);
        sc = int'(sample_count);
        arm = 1'b1;
        step();
        step();
        arm = 1'b0;
        chk("arm_busy busy", 32'(busy), 32'd1);
        chk("arm_busy no_restart", 32'(int'(sample_count) >= sc), 32'd1);
        finish_cap("arm_busy", 1, jt, ca, d0);

        arm = 1'b1;
        abort = 1'b1;
        step();
        chk("arm_abort idle", 32'(busy), 32'd0);
        chk("arm_abort no_clear", 32'(fifo_clear), 32'd0);
        arm = 1'b0;
        abort = 1'b0;
        step();
        chk("arm_abort still_idle", 32'(busy), 32'd0);

        start_cap(8'h00, 8'h00, 1, 40, jt, ca, d0);
        wait_for("rst_mid", 0, 5);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid ctl", 32'({fifo_en, fifo_rnw, fifo_clear, out_valid,
                                busy, triggered, done}), 32'b0100000);
        chk("rst_mid out_data", 32'(out_data), 32'd0);
        chk("rst_mid sample_count", 32'(sample_count), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_mid idle", 32'(busy), 32'd0);

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
